// File: rtl/romulus_ctrl_sequencer.sv
// Command-driven control sequencer for romulus_datapath.
//
// Accepts one opcode at a time from the mode-level FSM and drives every
// datapath control line cycle by cycle: register resets, enables, tbc/correct
// selects, the SKINNY round-constant stream and the domain byte.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_op              0 INIT, 1 LOAD_KEY, 2 LOAD_TWEAK, 3 ABSORB, 4 TBC,
//                       5 CNT_INC, 6/7 NOP
//   cmd_domain          domain byte, captured on accept
//   cmd_decrypt         decrypt select for ABSORB, captured on accept
//   done                pulse on the last control cycle of a command
//   constant            UNROLL round constants, earliest in the low slot
//   decrypt, domain     captured fields presented to the datapath
//   s/x/y/z rst,en,enc  state/key/tweak/counter register controls
//   erst, tk1s          tied 0
//   correct_cnt         counter-only increment select
module romulus_ctrl_sequencer #(
    parameter int unsigned BUSWIDTH = 128,
    parameter int unsigned ROUNDS   = 40,
    parameter int unsigned UNROLL   = 1,
    localparam int unsigned CW      = 6 * UNROLL,
    localparam int unsigned DW      = BUSWIDTH / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [7:0]    cmd_domain,
    input  logic          cmd_decrypt,
    output logic          done,
    output logic [CW-1:0] constant,
    output logic [DW-1:0] decrypt,
    output logic [7:0]    domain,
    output logic          srst,
    output logic          sen,
    output logic          senc,
    output logic          xrst,
    output logic          xen,
    output logic          xenc,
    output logic          yrst,
    output logic          yen,
    output logic          yenc,
    output logic          zrst,
    output logic          zen,
    output logic          zenc,
    output logic          erst,
    output logic          correct_cnt,
    output logic          tk1s
);

    localparam int unsigned Beats   = 128 / BUSWIDTH;
    localparam int unsigned RndCyc  = ROUNDS / UNROLL;
    localparam int unsigned CntMax  = (Beats > RndCyc) ? Beats : RndCyc;
    localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] BeatsLast = CntW'(Beats - 1);
    localparam logic [CntW-1:0] RndLast   = CntW'(RndCyc - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    localparam logic [2:0] OpInit   = 3'd0;
    localparam logic [2:0] OpLdKey  = 3'd1;
    localparam logic [2:0] OpLdTwk  = 3'd2;
    localparam logic [2:0] OpAbsorb = 3'd3;
    localparam logic [2:0] OpTbc    = 3'd4;
    localparam logic [2:0] OpCntInc = 3'd5;

    typedef enum logic [3:0] {
        StIdle, StInit, StLdKey, StLdTwk, StAbsorb, StRound, StCorrect, StCnt, StNop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      rc_q, rc_d;
    logic [7:0]      domain_q, domain_d;
    logic            decrypt_q, decrypt_d;
    logic [CW-1:0]   rc_slots;
    logic [5:0]      rc_adv;

    function automatic logic [5:0] rc_step(input logic [5:0] rc);
        return {rc[4:0], ~(rc[5] ^ rc[4])};
    endfunction

    // UNROLL consecutive LFSR values for this cycle, and the value UNROLL steps on.
    always_comb begin
        logic [5:0] rc_walk;
        rc_walk  = rc_q;
        rc_slots = '0;
        for (int j = 0; j < int'(UNROLL); j++) begin
            rc_slots[6*j +: 6] = rc_walk;
            rc_walk            = rc_step(rc_walk);
        end
        rc_adv = rc_walk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rc_q      <= 6'h01;
            domain_q  <= 8'h00;
            decrypt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rc_q      <= rc_d;
            domain_q  <= domain_d;
            decrypt_q <= decrypt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rc_d      = rc_q;
        domain_d  = domain_q;
        decrypt_d = decrypt_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cnt_d     = '0;
                    domain_d  = cmd_domain;
                    decrypt_d = cmd_decrypt;
                    case (cmd_op)
                        OpInit:   state_d = StInit;
                        OpLdKey:  state_d = StLdKey;
                        OpLdTwk:  state_d = StLdTwk;
                        OpAbsorb: state_d = StAbsorb;
                        OpTbc: begin
                            state_d = StRound;
                            rc_d    = 6'h01;
                        end
                        OpCntInc: state_d = StCnt;
                        default:  state_d = StNop;
                    endcase
                end
            end
            StLdKey, StLdTwk, StAbsorb: begin
                if (cnt_q == BeatsLast) state_d = StIdle;
                else                    cnt_d   = cnt_q + CntOne;
            end
            StRound: begin
                rc_d = rc_adv;
                if (cnt_q == RndLast) state_d = StCorrect;
                else                  cnt_d   = cnt_q + CntOne;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        done        = 1'b0;
        constant    = '0;
        decrypt     = '0;
        domain      = (state_q == StIdle) ? 8'h00 : domain_q;
        srst        = 1'b0;
        sen         = 1'b0;
        senc        = 1'b0;
        xrst        = 1'b0;
        xen         = 1'b0;
        xenc        = 1'b0;
        yrst        = 1'b0;
        yen         = 1'b0;
        yenc        = 1'b0;
        zrst        = 1'b0;
        zen         = 1'b0;
        zenc        = 1'b0;
        erst        = 1'b0;
        correct_cnt = 1'b0;
        tk1s        = 1'b0;
        case (state_q)
            StIdle: cmd_ready = 1'b1;
            StInit: begin
                srst = 1'b1;
                zrst = 1'b1;
                done = 1'b1;
            end
            StLdKey: begin
                xrst = 1'b1;
                done = (cnt_q == BeatsLast);
            end
            StLdTwk: begin
                yrst = 1'b1;
                done = (cnt_q == BeatsLast);
            end
            StAbsorb: begin
                sen     = 1'b1;
                decrypt = {DW{decrypt_q}};
                done    = (cnt_q == BeatsLast);
            end
            StRound: begin
                sen      = 1'b1;
                senc     = 1'b1;
                xen      = 1'b1;
                xenc     = 1'b1;
                yen      = 1'b1;
                yenc     = 1'b1;
                zen      = 1'b1;
                zenc     = 1'b1;
                constant = rc_slots;
            end
            StCorrect: begin
                xen  = 1'b1;
                yen  = 1'b1;
                zen  = 1'b1;
                done = 1'b1;
            end
            StCnt: begin
                zen         = 1'b1;
                correct_cnt = 1'b1;
                done        = 1'b1;
            end
            StNop:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_romulus_ctrl_sequencer.sv
// Bench for romulus_ctrl_sequencer. Main instance: BUSWIDTH=32, UNROLL=1.
// Second instance: BUSWIDTH=128, UNROLL=2, used for the unrolled TBC stream.
module tb_romulus_ctrl_sequencer;

    localparam int Beats = 4;
    localparam int Rounds = 40;

    typedef struct packed {
        logic       done;
        logic       ready;
        logic       srst, sen, senc;
        logic       xrst, xen, xenc;
        logic       yrst, yen, yenc;
        logic       zrst, zen, zenc;
        logic       erst, ccnt, tk1s;
        logic [3:0] dec;
        logic [7:0] dom;
        logic [5:0] cst;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance signals
    logic       cmd_valid = 1'b0, cmd_ready, cmd_decrypt = 1'b0, done;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_domain = 8'h00, domain;
    logic [5:0] constant;
    logic [3:0] decrypt;
    logic srst, sen, senc, xrst, xen, xenc, yrst, yen, yenc, zrst, zen, zenc;
    logic erst, correct_cnt, tk1s;

    // unrolled instance signals
    logic        u2_valid = 1'b0, u2_ready, u2_decrypt_in = 1'b0, u2_done;
    logic [2:0]  u2_op = 3'd0;
    logic [7:0]  u2_domain_in = 8'h00, u2_domain;
    logic [11:0] u2_constant;
    logic [15:0] u2_decrypt;
    logic u2_srst, u2_sen, u2_senc, u2_xrst, u2_xen, u2_xenc, u2_yrst, u2_yen, u2_yenc;
    logic u2_zrst, u2_zen, u2_zenc, u2_erst, u2_ccnt, u2_tk1s;

    int total = 0;
    int bad = 0;
    ctl_t exp_q[$];

    romulus_ctrl_sequencer #(.BUSWIDTH(32), .ROUNDS(40), .UNROLL(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_domain(cmd_domain), .cmd_decrypt(cmd_decrypt),
        .done(done), .constant(constant), .decrypt(decrypt), .domain(domain),
        .srst(srst), .sen(sen), .senc(senc), .xrst(xrst), .xen(xen), .xenc(xenc),
        .yrst(yrst), .yen(yen), .yenc(yenc), .zrst(zrst), .zen(zen), .zenc(zenc),
        .erst(erst), .correct_cnt(correct_cnt), .tk1s(tk1s)
    );

    romulus_ctrl_sequencer #(.BUSWIDTH(128), .ROUNDS(40), .UNROLL(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(u2_valid), .cmd_ready(u2_ready),
        .cmd_op(u2_op), .cmd_domain(u2_domain_in), .cmd_decrypt(u2_decrypt_in),
        .done(u2_done), .constant(u2_constant), .decrypt(u2_decrypt), .domain(u2_domain),
        .srst(u2_srst), .sen(u2_sen), .senc(u2_senc), .xrst(u2_xrst), .xen(u2_xen),
        .xenc(u2_xenc), .yrst(u2_yrst), .yen(u2_yen), .yenc(u2_yenc), .zrst(u2_zrst),
        .zen(u2_zen), .zenc(u2_zenc), .erst(u2_erst), .correct_cnt(u2_ccnt), .tk1s(u2_tk1s)
    );

    function automatic logic [5:0] rc_next(input logic [5:0] r);
        return {r[4:0], r[5] ^ r[4] ^ 1'b1};
    endfunction

    function automatic ctl_t obs();
        ctl_t c;
        c.done = done;  c.ready = cmd_ready;
        c.srst = srst;  c.sen = sen;  c.senc = senc;
        c.xrst = xrst;  c.xen = xen;  c.xenc = xenc;
        c.yrst = yrst;  c.yen = yen;  c.yenc = yenc;
        c.zrst = zrst;  c.zen = zen;  c.zenc = zenc;
        c.erst = erst;  c.ccnt = correct_cnt;  c.tk1s = tk1s;
        c.dec = decrypt;  c.dom = domain;  c.cst = constant;
        return c;
    endfunction

    function automatic ctl_t busy_vec(input logic [7:0] dom);
        ctl_t c = '0;
        c.dom = dom;
        return c;
    endfunction

    function automatic ctl_t idle_vec();
        ctl_t c = '0;
        c.ready = 1'b1;
        return c;
    endfunction

    // Expected control cycles of one command, from the command description.
    task automatic push_cmd(input logic [2:0] op, input logic [7:0] dom, input logic dec);
        ctl_t c;
        logic [5:0] rc;
        case (op)
            3'd0: begin
                c = busy_vec(dom); c.srst = 1'b1; c.zrst = 1'b1; c.done = 1'b1;
                exp_q.push_back(c);
            end
            3'd1, 3'd2, 3'd3: begin
                for (int i = 0; i < Beats; i++) begin
                    c = busy_vec(dom);
                    if (op == 3'd1) c.xrst = 1'b1;
                    else if (op == 3'd2) c.yrst = 1'b1;
                    else begin
                        c.sen = 1'b1;
                        c.dec = {4{dec}};
                    end
                    c.done = (i == Beats - 1);
                    exp_q.push_back(c);
                end
            end
            3'd4: begin
                rc = 6'h01;
                for (int i = 0; i < Rounds; i++) begin
                    c = busy_vec(dom);
                    {c.sen, c.senc, c.xen, c.xenc, c.yen, c.yenc, c.zen, c.zenc} = 8'hFF;
                    c.cst = rc;
                    rc = rc_next(rc);
                    exp_q.push_back(c);
                end
                c = busy_vec(dom); c.xen = 1'b1; c.yen = 1'b1; c.zen = 1'b1; c.done = 1'b1;
                exp_q.push_back(c);
            end
            3'd5: begin
                c = busy_vec(dom); c.zen = 1'b1; c.ccnt = 1'b1; c.done = 1'b1;
                exp_q.push_back(c);
            end
            default: begin
                c = busy_vec(dom); c.done = 1'b1;
                exp_q.push_back(c);
            end
        endcase
    endtask

    // Issue one command on the main instance and queue its expected cycles.
    task automatic send(input logic [2:0] op, input logic [7:0] dom, input logic dec);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: cmd_ready=%b required=1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_domain = dom; cmd_decrypt = dec;
        push_cmd(op, dom, dec);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        ctl_t o;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = obs();
        total++;
        if (o !== idle_vec()) begin
            bad++; $display("FAIL reset_state: got %h required %h", o, idle_vec());
        end
        total++;
        if (u2_ready !== 1'b1 || u2_constant !== 12'h000 || u2_done !== 1'b0) begin
            bad++; $display("FAIL reset_u2: ready=%b const=%h done=%b required 1/000/0",
                            u2_ready, u2_constant, u2_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_tbc(input logic [7:0] dom);
        ctl_t e, o;
        logic [5:0] tbl [8] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B};
        int i = 0;
        send(3'd4, dom, 1'b0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs();
            total++;
            if (o !== e) begin
                bad++; $display("FAIL tbc_cycle%0d: got %h required %h", i, o, e);
            end
            if (i < 8) begin
                total++;
                if (o.cst !== tbl[i]) begin
                    bad++; $display("FAIL tbc_rc%0d: got %h required %h", i, o.cst, tbl[i]);
                end
            end
            i++;
        end
        @(negedge clk);
        o = obs();
        total++;
        if (o !== idle_vec()) begin
            bad++; $display("FAIL tbc_ready_after: got %h required %h", o, idle_vec());
        end
    endtask

    task automatic test_load_absorb();
        ctl_t e, o;
        logic [2:0] ops [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd5};
        logic [7:0] doms [5] = '{8'h00, 8'h13, 8'h40, 8'h41, 8'h2C};
        logic decs [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            int i = 0;
            send(ops[k], doms[k], decs[k]);
            while (exp_q.size() > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                o = obs();
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL op%0d_cycle%0d: got %h required %h", ops[k], i, o, e);
                end
                i++;
            end
            @(negedge clk);
            o = obs();
            total++;
            if (o !== idle_vec()) begin
                bad++; $display("FAIL op%0d_idle_after: got %h required %h", ops[k], o, idle_vec());
            end
        end
    endtask

    task automatic test_reset_mid_tbc();
        ctl_t e, o;
        send(3'd4, 8'h55, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs();
            total++;
            if (o !== e) begin
                bad++; $display("FAIL abort_round%0d: got %h required %h", i, o, e);
            end
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        o = obs();
        total++;
        if (o !== idle_vec()) begin
            bad++; $display("FAIL abort_idle: got %h required %h", o, idle_vec());
        end
        rst = 1'b0;
        test_tbc(8'hA3);
    endtask

    task automatic test_back_to_back();
        ctl_t e, o;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_ready: got %b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_domain = 8'h11; cmd_decrypt = 1'b0;
        push_cmd(3'd0, 8'h11, 1'b0);
        exp_q.push_back(idle_vec());
        push_cmd(3'd7, 8'h22, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs();
            total++;
            if (o !== e) begin
                bad++; $display("FAIL b2b_cycle%0d: got %h required %h", i, o, e);
            end
            if (i == 0) begin
                cmd_op = 3'd7; cmd_domain = 8'h22;
            end
            if (i == 2) cmd_valid = 1'b0;
        end
        @(negedge clk);
        o = obs();
        total++;
        if (o !== idle_vec()) begin
            bad++; $display("FAIL b2b_idle_after: got %h required %h", o, idle_vec());
        end
    endtask

    task automatic test_unroll2();
        logic [11:0] cq[$];
        logic [11:0] ce;
        logic [5:0] rc = 6'h01;
        for (int i = 0; i < 20; i++) begin
            cq.push_back({rc_next(rc), rc});
            rc = rc_next(rc_next(rc));
        end
        @(negedge clk);
        u2_valid = 1'b1; u2_op = 3'd4; u2_domain_in = 8'h5A;
        @(posedge clk);
        #1 u2_valid = 1'b0;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            @(negedge clk);
            if (cyc <= 20) begin
                ce = cq.pop_front();
                total++;
                if (u2_constant !== ce || u2_done !== 1'b0 || u2_senc !== 1'b1) begin
                    bad++; $display("FAIL u2_round%0d: const=%h done=%b senc=%b required %h/0/1",
                                    cyc, u2_constant, u2_done, u2_senc, ce);
                end
                if (cyc == 1) begin
                    total++;
                    if (u2_constant !== 12'h0C1) begin
                        bad++; $display("FAIL u2_first_const: got %h required 0c1", u2_constant);
                    end
                end
            end else begin
                total++;
                if (u2_done !== 1'b1 || u2_constant !== 12'h000 || u2_xen !== 1'b1 ||
                    u2_xenc !== 1'b0 || u2_domain !== 8'h5A) begin
                    bad++; $display("FAIL u2_correct: done=%b const=%h xen=%b xenc=%b dom=%h",
                                    u2_done, u2_constant, u2_xen, u2_xenc, u2_domain);
                end
            end
        end
        @(negedge clk);
        total++;
        if (u2_ready !== 1'b1) begin
            bad++; $display("FAIL u2_ready_after: got %b required 1", u2_ready);
        end
    endtask

    initial begin
        test_reset();
        test_tbc(8'h0F);
        test_load_absorb();
        test_reset_mid_tbc();
        test_back_to_back();
        test_unroll2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

endmodule

// File: doc/romulus_ctrl_sequencer.md
Name: romulus_ctrl_sequencer

Overview:
Command-driven control FSM for romulus_datapath. It accepts one opcode at a time and drives every datapath control line: register resets, enables and tbc/correct selects. During TBC runs it also generates the SKINNY round-constant stream and the domain byte. It sits between the mode-level (AEAD/hash) FSM and the datapath, and owns all cycle-level sequencing of key, tweak and counter loading, absorption, rounds and tweakey correction.

Parameters:
BUSWIDTH, 128, datapath pdi/sdi width; legal values 32, 64, 128; BEATS = 128/BUSWIDTH.
ROUNDS, 40, TBC rounds per invocation.
UNROLL, 1, rounds per datapath cycle; must divide ROUNDS; CW = 6*UNROLL.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_op  in  3  opcode: 0 INIT, 1 LOAD_KEY, 2 LOAD_TWEAK, 3 ABSORB, 4 TBC, 5 CNT_INC, 6/7 NOP
cmd_domain  in  8  domain byte, captured on accept
cmd_decrypt  in  1  decrypt select for ABSORB, captured on accept
done  out  1  one-cycle pulse on the last control cycle of a command
constant  out  CW  round constants; sub-round j in bits [6j+5:6j]
decrypt  out  BUSWIDTH/8  captured decrypt bit replicated to every byte during ABSORB, else 0
domain  out  8  captured domain byte; 0 in IDLE
srst, sen, senc  out  1 each  state register controls
xrst, xen, xenc  out  1 each  key register controls
yrst, yen, yenc  out  1 each  tweak register controls
zrst, zen, zenc  out  1 each  counter register controls
erst  out  1  tied 0
correct_cnt  out  1  counter-only increment select
tk1s  out  1  tied 0 (reserved)

Behaviour:
- States: IDLE, INIT, LDKEY, LDTWK, ABSORB, ROUND, CORRECT, CNT, NOP.
- All outputs decode from the state register, the beat/round counter and the captured fields. All are 0 in IDLE except cmd_ready = 1.
- Accept on cmd_valid & cmd_ready. Control cycles start on the next cycle. On accept, capture cmd_domain and cmd_decrypt.
- INIT: 1 cycle, srst = zrst = 1.
- LDKEY: BEATS cycles, xrst = 1.
- LDTWK: BEATS cycles, yrst = 1.
- ABSORB: BEATS cycles, sen = 1, senc = 0, decrypt = {BUSWIDTH/8{captured bit}}.
- TBC: ROUNDS/UNROLL ROUND cycles, then 1 CORRECT cycle.
  - ROUND: sen, senc, xen, xenc, yen, yenc, zen, zenc all 1.
  - CORRECT: xen = yen = zen = 1, all *enc = 0, correct_cnt = 0, domain = captured.
- CNT_INC: 1 cycle, zen = 1, zenc = 0, correct_cnt = 1, domain = captured.
- NOP: 1 cycle, no datapath control asserted.
- done is high on the final control cycle of each command. The FSM returns to IDLE on the next edge, so cmd_ready is high the cycle after done.
- Back-to-back throughput: one idle cycle between commands.
- Round constant LFSR (6 bits) is reset to 0x01 on TBC accept. Update rule: rc' = {rc[4:0], rc[5]^rc[4]^1}.
- Each ROUND cycle outputs UNROLL consecutive rc values, the earliest in the low slot, then advances UNROLL steps. constant = 0 outside ROUND.
- The beat/round counter is sized for max(BEATS, ROUNDS/UNROLL) and clears on every accept. No wrap occurs within a command.
- rst at any time: next cycle is IDLE, all controls are 0, and the command is dropped with no done pulse. The datapath registers are not reset by this; software reissues INIT.
- cmd_valid while busy is ignored (cmd_ready = 0). Unknown opcodes 6/7 run as NOP.

Test Plan:
- Reset, then TBC, UNROLL = 1 -> 40 ROUND cycles with constant 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3E, 0x3D, 0x3B…. Then 1 CORRECT cycle with xen = yen = zen = 1, enc = 0, domain = cmd_domain. done on the CORRECT cycle; cmd_ready high the following cycle.
- UNROLL = 2, TBC -> 20 ROUND cycles; constant = 12'h0C1, then 12'h3C7, …. Total busy = 21 cycles.
- BUSWIDTH = 32: LOAD_KEY -> xrst high exactly 4 cycles. ABSORB with cmd_decrypt = 1 -> decrypt = 4'hF with sen = 1, senc = 0 for 4 cycles.
- CNT_INC with cmd_domain = 8'h2C -> 1 cycle of zen = 1, correct_cnt = 1, domain = 8'h2C, done; all other enables 0.
- rst asserted in ROUND cycle 10 -> all controls 0 the next cycle, no done, cmd_ready = 1. A following TBC starts again with constant 0x01.
- cmd_valid held with INIT then op 7 back-to-back -> INIT accepted (srst = zrst = 1 for 1 cycle), one idle cycle, then NOP done pulse with no datapath control asserted.
